// File: rtl/cr_writeback.sv
// Condition-register writeback: in-order queue of record-form and mtcrf updates, one retired per cycle.
// Optional macro CR_BYPASS_EN: rd_cr forwards the youngest pending value and hazard is tied low.
module cr_writeback #(
    parameter int QDEPTH  = 2,
    parameter int NFIELDS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_rc,
    input  logic [2:0]  in_field,
    input  logic [3:0]  in_cr,
    input  logic        in_mtcrf,
    input  logic [7:0]  in_mask,
    input  logic [31:0] in_value,
    input  logic        xer_so,
    input  logic        wb_stall,
    input  logic [2:0]  rd_field,
    output logic [3:0]  rd_cr,
    output logic [31:0] cr_all,
    output logic        busy,
    output logic        hazard
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    // Every entry is held as a field mask plus a 32-bit word, so rc updates become one-field mtcrf writes.
    logic [7:0]    mask_q  [QDEPTH];
    logic [31:0]   value_q [QDEPTH];
    logic [7:0]    mask_d  [QDEPTH];
    logic [31:0]   value_d [QDEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   cr_q, cr_d;
    logic          accept_s, enq_s, retire_s;
    logic [7:0]    new_mask_s;
    logic [31:0]   new_value_s;
    logic          hit_s;
    logic [3:0]    byp_s;
    int            idx_s;
    logic          unused_so_s;

    assign unused_so_s = in_cr[0];

    function automatic logic [3:0] get_nib(input logic [31:0] w, input logic [2:0] f);
        logic [31:0] s;
        s = w >> (5'd28 - {f, 2'b00});
        return s[3:0];
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (int'(p) == QDEPTH - 1) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1'b1);
        end
        return r;
    endfunction

    assign accept_s = in_valid && in_ready;
    assign enq_s    = accept_s && (in_mtcrf || in_rc);
    assign retire_s = (count_q != {CW{1'b0}}) && !wb_stall;

    // Normalise the offered update into mask/value form
    always_comb begin
        new_mask_s  = 8'h00;
        new_value_s = 32'h0000_0000;
        if (in_mtcrf) begin
            new_mask_s  = in_mask;
            new_value_s = in_value;
        end else begin
            for (int f = 0; f < NFIELDS; f++) begin
                new_mask_s[7-f]        = (in_field == 3'(f));
                new_value_s[31-4*f -: 4] = (in_field == 3'(f)) ? {in_cr[3:1], xer_so} : 4'h0;
            end
        end
    end

    // Queue bookkeeping and CR retirement
    always_comb begin
        mask_d  = mask_q;
        value_d = value_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cr_d    = cr_q;
        if (retire_s) begin
            for (int f = 0; f < NFIELDS; f++) begin
                cr_d[31-4*f -: 4] = mask_q[head_q][7-f] ? value_q[head_q][31-4*f -: 4]
                                                         : cr_q[31-4*f -: 4];
            end
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (enq_s) begin
            mask_d[tail_q]  = new_mask_s;
            value_d[tail_q] = new_value_s;
            tail_d          = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        case ({enq_s, retire_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mask_q[i]  <= 8'h00;
                value_q[i] <= 32'h0000_0000;
            end
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            cr_q    <= 32'h0000_0000;
        end else begin
            mask_q  <= mask_d;
            value_q <= value_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cr_q    <= cr_d;
        end
    end

    // Scan pending entries oldest to youngest so the last match is the youngest writer
    always_comb begin
        hit_s = 1'b0;
        byp_s = 4'h0;
        idx_s = 0;
        for (int i = 0; i < QDEPTH; i++) begin
            idx_s = (int'(head_q) + i) % QDEPTH;
            if ((CW'(i) < count_q) && mask_q[idx_s][3'd7 - rd_field]) begin
                hit_s = 1'b1;
                byp_s = get_nib(value_q[idx_s], rd_field);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign in_ready = (count_q < CW'(QDEPTH));
    assign busy     = (count_q != {CW{1'b0}});
    assign cr_all   = cr_q;
`ifdef CR_BYPASS_EN
    assign rd_cr    = hit_s ? byp_s : get_nib(cr_q, rd_field);
    assign hazard   = 1'b0;
`else
    logic [3:0] unused_byp_s;
    assign unused_byp_s = byp_s;
    assign rd_cr    = get_nib(cr_q, rd_field);
    assign hazard   = hit_s;
`endif
endmodule

// File: tb/tb_cr_writeback.sv
// Randomised scoreboard bench for cr_writeback with a field-level reference model.
module tb_cr_writeback;
    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_rc, in_mtcrf, xer_so, wb_stall, busy, hazard;
    logic [2:0]  in_field, rd_field;
    logic [3:0]  in_cr, rd_cr;
    logic [7:0]  in_mask;
    logic [31:0] in_value, cr_all;

    cr_writeback #(.QDEPTH(QD), .NFIELDS(8)) dut (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rc(in_rc), .in_field(in_field), .in_cr(in_cr), .in_mtcrf(in_mtcrf),
        .in_mask(in_mask), .in_value(in_value), .xer_so(xer_so), .wb_stall(wb_stall),
        .rd_field(rd_field), .rd_cr(rd_cr), .cr_all(cr_all), .busy(busy), .hazard(hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        mt;
        int        field;
        bit [3:0]  nib_rc;
        bit [7:0]  mask;
        bit [31:0] value;
    } upd_t;

    upd_t        pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] future_cr = 32'h0;
    logic [31:0] arch_cr = 32'h0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic bit targets(upd_t u, int f);
        return u.mt ? u.mask[7-f] : (u.field == f);
    endfunction

    function automatic bit [3:0] nib_of(upd_t u, int f);
        bit [31:0] s;
        s = u.value >> (28 - 4*f);
        return u.mt ? s[3:0] : u.nib_rc;
    endfunction

    function automatic logic [3:0] cr_field(logic [31:0] cr, int f);
        logic [31:0] s;
        s = cr >> (28 - 4*f);
        return s[3:0];
    endfunction

    function automatic logic [31:0] apply(logic [31:0] cr, upd_t u);
        logic [31:0] r;
        r = cr;
        for (int f = 0; f < 8; f++)
            if (targets(u, f)) r[31-4*f -: 4] = nib_of(u, f);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // One offered cycle; the expected CR after this entry is queued once the accept edge has passed
    task automatic cyc(input bit v, input bit rc, input int fld, input bit [3:0] cr, input bit mt,
                       input bit [7:0] msk, input bit [31:0] val, input bit so, input bit stall,
                       input int rdf);
        upd_t u;
        bit   acc;
        @(negedge clk); #1;
        in_valid = v; in_rc = rc; in_field = 3'(fld); in_cr = cr; in_mtcrf = mt;
        in_mask = msk; in_value = val; xer_so = so; wb_stall = stall; rd_field = 3'(rdf);
        acc = v && (pend.size() < QD) && (mt || rc);
        u.mt = mt; u.field = fld; u.nib_rc = {cr[3:1], so}; u.mask = msk; u.value = val;
        @(posedge clk); #1;
        if (acc) begin
            pend.push_back(u);
            future_cr = apply(future_cr, u);
            exp_q.push_back(future_cr);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; wb_stall = 1'b0;
        pend.delete(); exp_q.delete(); future_cr = 32'h0;
        repeat (cycles) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // Retirement predicted from the model: pop scoreboard at each retiring edge
    always @(posedge clk) begin
        upd_t u;
        if (!rst && pend.size() > 0 && !wb_stall) begin
            u = pend.pop_front();
            arch_cr = exp_q.pop_front();
        end
    end

    // Per-cycle comparison of all observable outputs
    always @(negedge clk) begin
        bit         exp_hz;
        logic [3:0] exp_rd;
        if (rst) arch_cr = 32'h0;
        exp_hz = 1'b0;
        exp_rd = cr_field(arch_cr, int'(rd_field));
        foreach (pend[i]) begin
            if (targets(pend[i], int'(rd_field))) begin
                exp_hz = 1'b1;
`ifdef CR_BYPASS_EN
                exp_rd = nib_of(pend[i], int'(rd_field));
`endif
            end
        end
`ifdef CR_BYPASS_EN
        exp_hz = 1'b0;
`endif
        chk("cr_all", cr_all, arch_cr);
        chk("in_ready", 32'(in_ready), 32'(pend.size() < QD));
        chk("busy", 32'(busy), 32'(pend.size() != 0));
        chk("hazard", 32'(hazard), 32'(exp_hz));
        chk("rd_cr", 32'(rd_cr), 32'(exp_rd));
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rc = 1'b0; in_field = 3'd0; in_cr = 4'h0;
        in_mtcrf = 1'b0; in_mask = 8'h00; in_value = 32'h0; xer_so = 1'b0;
        wb_stall = 1'b0; rd_field = 3'd0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_cr", cr_all, 32'h0000_0000);
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hazard", 32'(hazard), 32'd0);

        cyc(1'b1, 1'b1, 0, 4'b0010, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 0);
        @(negedge clk); @(negedge clk);
        chk("rc_f0", cr_all, 32'h3000_0000);
        chk("rc_f0_busy", 32'(busy), 32'd0);

        do_reset(1);
        cyc(1'b1, 1'b0, 0, 4'h0, 1'b1, 8'h81, 32'h1234_5678, 1'b0, 1'b0, 7);
        @(negedge clk); @(negedge clk);
        chk("mtcrf_81", cr_all, 32'h1000_0008);

        do_reset(1);
        cyc(1'b1, 1'b1, 5, 4'b1000, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 5);
        cyc(1'b1, 1'b1, 5, 4'b0100, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 5);
        @(negedge clk);
        chk("full_ready", 32'(in_ready), 32'd0);
        cyc(1'b1, 1'b1, 1, 4'b1110, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1);
        cyc(1'b0, 1'b0, 0, 4'h0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 5);
        @(negedge clk); @(negedge clk);
        chk("stall_order", cr_all, 32'h0000_0400);

        do_reset(1);
        cyc(1'b1, 1'b1, 3, 4'b0100, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 3);
        @(negedge clk);
`ifdef CR_BYPASS_EN
        chk("pend_hazard", 32'(hazard), 32'd0);
        chk("pend_rd", 32'(rd_cr), 32'h4);
`else
        chk("pend_hazard", 32'(hazard), 32'd1);
        chk("pend_rd", 32'(rd_cr), 32'h0);
`endif

        do_reset(1);
        cyc(1'b1, 1'b1, 0, 4'b1110, 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 0);
        cyc(1'b1, 1'b0, 0, 4'h0, 1'b1, 8'hff, 32'hdead_beef, 1'b0, 1'b1, 0);
        do_reset(2);
        repeat (3) @(negedge clk);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_cr", cr_all, 32'h0000_0000);

        for (int n = 0; n < 600; n++) begin
            bit [7:0] m;
            m = ($urandom_range(4, 0) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(150, 0) == 0) do_reset(1);
            cyc($urandom_range(3, 0) != 0, 1'($urandom), int'($urandom_range(7, 0)),
                4'($urandom), ($urandom_range(2, 0) == 0), m, $urandom, 1'($urandom),
                ($urandom_range(3, 0) == 0), int'($urandom_range(7, 0)));
        end
        for (int n = 0; n < 4; n++)
            cyc(1'b0, 1'b0, 0, 4'h0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, n);
        @(negedge clk);
        chk("drained_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
